// File: rtl/boa_mdu_seq_if.sv
// Issue/writeback handshake bundle for the RV32M sequencer.
// The upstream side offers one op (valid/ready) and the downstream side drains
// one tagged result (valid/ready).
interface boa_mdu_seq_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [31:0]      in_lhs;
  logic [31:0]      in_rhs;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [TAG_W-1:0] out_tag;

  // Driver side: issue stage plus writeback arbiter.
  modport master (
    output in_valid, in_funct3, in_lhs, in_rhs, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_funct3, in_lhs, in_rhs, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag
  );
endinterface

// File: rtl/boa_mdu_seq.sv
// RV32M execute-slot sequencer: single-cycle multiplier, multi-cycle restoring
// divider, and a tagged output register held until writeback takes it.
// The divider retires STEPS quotient bits per clock so that DIV_DELAY rounds
// cover all 32 bits; the first round runs on the accept edge itself, which
// makes a result visible exactly DIV_DELAY cycles after the accept cycle.
module boa_mdu_seq #(
  parameter int DIV_DELAY = 8,
  parameter int TAG_W     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  output logic busy,
  boa_mdu_seq_if.slave bus
);
  localparam int STEPS   = (32 + DIV_DELAY - 1) / DIV_DELAY;
  localparam int N       = DIV_DELAY * STEPS;  // dividend width, zero-extended past 32
  localparam int CNT_W   = 6;                  // holds DIV_DELAY-1 up to 31
  localparam bit DIV_ONE = (DIV_DELAY == 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state_reg, state_next;
  logic             accept, mul_acc, div_latch, div_step, div_final;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      rem_reg, divisor_reg;
  logic [N-1:0]     quo_reg;
  logic             neg_q_reg, neg_r_reg, sel_rem_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [31:0]      out_res_reg;
  logic [TAG_W-1:0] out_tag_reg;

  // Operand conditioning and current divider context (live inputs on the accept edge).
  logic             a_neg, b_neg;
  logic [31:0]      a_mag, b_mag, cur_divisor, cur_rem;
  logic [N-1:0]     cur_quo;
  logic             cur_neg_q, cur_neg_r, cur_sel_rem;
  logic [TAG_W-1:0] cur_tag;

  assign a_neg       = !bus.in_funct3[0] && bus.in_lhs[31];
  assign b_neg       = !bus.in_funct3[0] && bus.in_rhs[31];
  assign a_mag       = a_neg ? (~bus.in_lhs + 32'd1) : bus.in_lhs;
  assign b_mag       = b_neg ? (~bus.in_rhs + 32'd1) : bus.in_rhs;
  assign cur_divisor = div_latch ? b_mag : divisor_reg;
  assign cur_rem     = div_latch ? 32'd0 : rem_reg;
  assign cur_quo     = div_latch ? N'(a_mag) : quo_reg;
  // A zero divisor must yield all-ones regardless of sign, so never negate it.
  assign cur_neg_q   = div_latch ? ((a_neg ^ b_neg) && (bus.in_rhs != 32'd0)) : neg_q_reg;
  assign cur_neg_r   = div_latch ? a_neg : neg_r_reg;
  assign cur_sel_rem = div_latch ? bus.in_funct3[1] : sel_rem_reg;
  assign cur_tag     = div_latch ? bus.in_tag : tag_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; flush overrides everything and returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (mul_acc || DIV_ONE) ? DONE : DIV;
      DIV:  if (cnt_reg == CNT_W'(1)) state_next = DONE;
      DONE: if (bus.out_ready) begin
              if (accept) state_next = (mul_acc || DIV_ONE) ? DONE : DIV;
              else        state_next = IDLE;
            end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Handshake and control outputs decoded from the current state.
  always_comb begin
    bus.in_ready  = !flush && (state_reg == IDLE || (state_reg == DONE && bus.out_ready));
    accept        = bus.in_valid && bus.in_ready;
    mul_acc       = accept && !bus.in_funct3[2];
    div_latch     = accept && bus.in_funct3[2];
    div_step      = (state_reg == DIV);
    div_final     = (div_latch && DIV_ONE) || (div_step && cnt_reg == CNT_W'(1) && !flush);
    bus.out_valid = (state_reg == DONE);
    busy          = (state_reg != IDLE);
  end

  // One divider round: STEPS restoring shift/subtract iterations.
  logic [32:0]  sh;
  logic         ge;
  logic [31:0]  r_w, rem_nx;
  logic [N-1:0] q_w, quo_nx;
  always_comb begin
    r_w = cur_rem;
    q_w = cur_quo;
    sh  = '0;
    ge  = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      sh = {r_w, q_w[N-1]};
      ge = (sh >= {1'b0, cur_divisor});
      if (ge) sh = sh - {1'b0, cur_divisor};
      r_w = sh[31:0];
      q_w = {q_w[N-2:0], ge};
    end
    rem_nx = r_w;
    quo_nx = q_w;
  end

  // Sign correction and quotient/remainder selection of the finished divide.
  logic [31:0] q32, div_res;
  assign q32     = quo_nx[31:0];
  assign div_res = cur_sel_rem ? (cur_neg_r ? (~rem_nx + 32'd1) : rem_nx)
                               : (cur_neg_q ? (~q32 + 32'd1) : q32);

  // Multiplier: operands extended to 64 bits per signedness; low 64 bits of the product suffice.
  logic        lhs_signed, rhs_signed;
  logic [63:0] lhs64, rhs64, prod;
  logic [31:0] mul_res;
  assign lhs_signed = (bus.in_funct3[1:0] != 2'b11);
  assign rhs_signed = !bus.in_funct3[1];
  assign lhs64      = {{32{lhs_signed & bus.in_lhs[31]}}, bus.in_lhs};
  assign rhs64      = {{32{rhs_signed & bus.in_rhs[31]}}, bus.in_rhs};
  assign prod       = lhs64 * rhs64;
  assign mul_res    = (bus.in_funct3[1:0] == 2'b00) ? prod[31:0] : prod[63:32];

  // Divider state, round counter and the held result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      sel_rem_reg <= 1'b0;
      tag_reg     <= '0;
      out_res_reg <= '0;
      out_tag_reg <= '0;
    end else begin
      if (div_latch) begin
        cnt_reg     <= CNT_W'(DIV_DELAY - 1);
        divisor_reg <= b_mag;
        neg_q_reg   <= cur_neg_q;
        neg_r_reg   <= a_neg;
        sel_rem_reg <= bus.in_funct3[1];
        tag_reg     <= bus.in_tag;
      end else if (div_step) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (div_latch || div_step) begin
        rem_reg <= rem_nx;
        quo_reg <= quo_nx;
      end
      if (mul_acc) begin
        out_res_reg <= mul_res;
        out_tag_reg <= bus.in_tag;
      end else if (div_final) begin
        out_res_reg <= div_res;
        out_tag_reg <= cur_tag;
      end
    end
  end

  assign bus.out_res = out_res_reg;
  assign bus.out_tag = out_tag_reg;
endmodule

// File: tb/tb_boa_mdu_seq.sv
// Self-checking bench for boa_mdu_seq with DIV_DELAY=8, TAG_W=5.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_boa_mdu_seq;
  localparam int DD = 8;

  logic clk = 1'b0;
  logic rst, flush, busy;

  boa_mdu_seq_if #(.TAG_W(5)) bus();

  boa_mdu_seq #(.DIV_DELAY(DD), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  // Reference RV32M arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sv, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sv = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: return a * b;
      3'd1: begin p = sa * sv; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sv);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sv);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f;
    bus.in_lhs    = a;
    bus.in_rhs    = b;
    bus.in_tag    = t;
  endtask

  // Deassert valid and scramble operands to prove the divider latched them.
  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_lhs   = $urandom;
    bus.in_rhs   = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
    bus.in_funct3 = 3'd0; bus.in_tag = 5'd0;
    idle_in();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: out_valid=%b busy=%b expected 0 0", bus.out_valid, busy);
    end
    checks++;
    if (bus.out_res !== 32'd0 || bus.out_tag !== 5'd0) begin
      errors++; $display("FAIL reset_data: out_res=%h out_tag=%0d expected 0 0", bus.out_res, bus.out_tag);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_mul_back_to_back();
    bus.out_ready = 1'b1;
    drive(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3);
    sb.push_back('{32'hFFFF_FFEB, 5'd3});
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL mul_latency: out_valid=%b expected 1", bus.out_valid);
    end
    e = sb.pop_front();
    checks++;
    if (bus.out_res !== e.res || bus.out_tag !== e.tag) begin
      errors++; $display("FAIL mul0: res=%h tag=%0d expected res=%h tag=%0d", bus.out_res, bus.out_tag, e.res, e.tag);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL mul_b2b_ready: in_ready=%b expected 1", bus.in_ready);
    end
    drive(3'd0, 32'h1234_5678, 32'h10, 5'd4);
    sb.push_back('{32'h2345_6780, 5'd4});
    @(negedge clk);
    idle_in();
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_res !== e.res || bus.out_tag !== e.tag) begin
      errors++; $display("FAIL mul1: valid=%b res=%h tag=%0d expected 1 res=%h tag=%0d", bus.out_valid, bus.out_res, bus.out_tag, e.res, e.tag);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mul_drain: out_valid=%b busy=%b expected 0 0", bus.out_valid, busy);
    end
  endtask

  task automatic test_mulh();
    logic [31:0] exp_h [3];
    exp_h = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'(i + 1), 32'h8000_0000, 32'h8000_0000, 5'(10 + i));
      sb.push_back('{exp_h[i], 5'(10 + i)});
      @(negedge clk);
      idle_in();
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_res !== e.res || bus.out_tag !== e.tag) begin
        errors++; $display("FAIL mulh f=%0d: valid=%b res=%h tag=%0d expected 1 res=%h tag=%0d", i + 1, bus.out_valid, bus.out_res, bus.out_tag, e.res, e.tag);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div();
    logic [2:0]  fs [8];
    logic [31:0] as [8];
    logic [31:0] bs [8];
    logic [31:0] xs [8];
    bit stall_err;
    fs = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    as = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    bs = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    xs = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(fs[i], as[i], bs[i], 5'(20 + i));
      sb.push_back('{xs[i], 5'(20 + i)});
      @(negedge clk);
      stall_err = 1'b0;
      for (int k = 1; k < DD; k++) begin
        idle_in();
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b1) stall_err = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (stall_err) begin
        errors++; $display("FAIL div_wait case %0d: out_valid/in_ready/busy got 1/1/0 at some wait cycle, expected 0/0/1", i);
      end
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_res !== e.res || bus.out_tag !== e.tag) begin
        errors++; $display("FAIL div case %0d: valid=%b res=%h tag=%0d expected 1 res=%h tag=%0d", i, bus.out_valid, bus.out_res, bus.out_tag, e.res, e.tag);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(3'd0, 32'd3, 32'd5, 5'd9);
    sb.push_back('{32'd15, 5'd9});
    @(negedge clk);
    drive(3'd0, 32'd6, 32'd7, 5'd10);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_res !== sb[0].res || bus.out_tag !== sb[0].tag ||
          bus.in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold cycle %0d: valid=%b res=%h tag=%0d in_ready=%b busy=%b expected 1 res=%h tag=%0d 0 1",
                           k, bus.out_valid, bus.out_res, bus.out_tag, bus.in_ready, busy, sb[0].res, sb[0].tag);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_handover_ready: in_ready=%b expected 1", bus.in_ready);
    end
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_res !== e.res || bus.out_tag !== e.tag) begin
      errors++; $display("FAIL bp_first: valid=%b res=%h tag=%0d expected 1 res=%h tag=%0d", bus.out_valid, bus.out_res, bus.out_tag, e.res, e.tag);
    end
    sb.push_back('{32'd42, 5'd10});
    @(negedge clk);
    idle_in();
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_res !== e.res || bus.out_tag !== e.tag) begin
      errors++; $display("FAIL bp_second: valid=%b res=%h tag=%0d expected 1 res=%h tag=%0d", bus.out_valid, bus.out_res, bus.out_tag, e.res, e.tag);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit stale;
    // Kill a divide in its fourth cycle while an op is offered alongside the flush.
    bus.out_ready = 1'b1;
    drive(3'd4, 32'd100, 32'd7, 5'd5);
    @(negedge clk);
    idle_in();
    repeat (3) @(negedge clk);
    flush = 1'b1;
    drive(3'd0, 32'd1, 32'd1, 5'd7);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: in_ready=%b expected 0", bus.in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    idle_in();
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle: out_valid=%b busy=%b expected 0 0", bus.out_valid, busy);
    end
    drive(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd6);
    sb.push_back('{32'd1, 5'd6});
    @(negedge clk);
    idle_in();
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_res !== e.res || bus.out_tag !== e.tag) begin
      errors++; $display("FAIL flush_mulhu: valid=%b res=%h tag=%0d expected 1 res=%h tag=%0d", bus.out_valid, bus.out_res, bus.out_tag, e.res, e.tag);
    end
    stale = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++; $display("FAIL flush_stale: out_valid=1 seen after flush, expected 0");
    end

    // A held result is dropped by flush even with out_ready high.
    bus.out_ready = 1'b0;
    drive(3'd0, 32'd2, 32'd3, 5'd8);
    @(negedge clk);
    idle_in();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_held_pre: out_valid=%b expected 1", bus.out_valid);
    end
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_drop_held: out_valid=%b busy=%b expected 0 0", bus.out_valid, busy);
    end

    // Same divide killed by reset instead; the held data registers clear too.
    drive(3'd4, 32'd100, 32'd7, 5'd5);
    @(negedge clk);
    idle_in();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_res !== 32'd0 || bus.out_tag !== 5'd0) begin
      errors++; $display("FAIL rst_mid: valid=%b busy=%b res=%h tag=%0d expected 0 0 0 0", bus.out_valid, busy, bus.out_res, bus.out_tag);
    end
    stale = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++; $display("FAIL rst_stale: out_valid=1 seen after reset, expected 0");
    end
  endtask

  task automatic test_random();
    int n_issued, n_done, cyc;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  t;
    n_issued = 0; n_done = 0; cyc = 0;
    while (n_done < 40 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected: res=%h tag=%0d with no op outstanding", bus.out_res, bus.out_tag);
        end else begin
          e = sb.pop_front();
          if (bus.out_res !== e.res || bus.out_tag !== e.tag) begin
            errors++; $display("FAIL rnd op %0d: res=%h tag=%0d expected res=%h tag=%0d", n_done, bus.out_res, bus.out_tag, e.res, e.tag);
          end
        end
        n_done++;
      end
      if (bus.in_ready === 1'b1 && n_issued < 40) begin
        f = 3'($urandom_range(0, 7));
        a = rand_operand();
        b = rand_operand();
        t = 5'($urandom_range(0, 31));
        drive(f, a, b, t);
        sb.push_back('{ref_mdu(f, a, b), t});
        n_issued++;
      end else begin
        idle_in();
      end
    end
    checks++;
    if (n_done != 40 || sb.size() != 0) begin
      errors++; $display("FAIL rnd_count: completed=%0d outstanding=%0d expected 40 0", n_done, sb.size());
    end
    idle_in();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul_back_to_back();
    test_mulh();
    test_div();
    test_backpressure();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
